// File: rtl/io_bridge_master.sv
// io_bridge_master: UART-driven debug initiator for the J1 IO bus.
// Parses 'R'/'W' command frames from the UART receive side, runs one IO
// bus cycle with J1 timing once the bus is granted, and answers with the
// read word (4 bytes, MSB first) or a '+' acknowledge byte.
module io_bridge_master #(
    parameter int unsigned TIMEOUT = 2500000
) (
    input  logic        clk,
    input  logic        resetq,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        rx_rd,
    input  logic        tx_busy,
    output logic        tx_wr,
    output logic [7:0]  tx_data,
    output logic        bus_req,
    input  logic        bus_gnt,
    output logic        io_rd,
    output logic        io_wr,
    output logic [15:0] mem_addr,
    output logic [31:0] dout,
    input  logic [31:0] io_din
);

    localparam logic [7:0] CMD_READ  = 8'h52;
    localparam logic [7:0] CMD_WRITE = 8'h57;
    localparam logic [7:0] ACK_BYTE  = 8'h2B;

    localparam int unsigned TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT);

    typedef enum logic [3:0] {
        S_IDLE,
        S_CMD,
        S_ADDR,
        S_DATA,
        S_REQ,
        S_RD0,
        S_RD1,
        S_WR,
        S_TX
    } state_t;

    state_t        state_q;
    logic          rx_rd_q;
    logic          tx_wr_q;
    logic          bus_req_q;
    logic          io_rd_q;
    logic          io_wr_q;
    logic [15:0]   mem_addr_q;
    logic [31:0]   dout_q;
    logic          is_wr_q;
    logic [15:0]   addr_sh_q;
    logic [31:0]   data_sh_q;
    logic [1:0]    data_cnt_q;
    logic [31:0]   rdata_q;
    logic [1:0]    tx_cnt_q;
    logic [TW-1:0] tmo_q;

    logic          tx_wr_d;
    logic [7:0]    tx_data_d;

    // A byte is taken only in the receiving states, and never in the cycle
    // right after a consume pulse (the UART has not yet presented the next byte).
    logic in_frame;
    logic take_byte;
    logic tmo_hit;
    logic tx_last;

    assign in_frame  = (state_q == S_CMD) || (state_q == S_ADDR) || (state_q == S_DATA);
    assign take_byte = ((state_q == S_IDLE) || in_frame) && rx_valid && !rx_rd_q;
    assign tmo_hit   = (tmo_q == TMO_MAX);
    assign tx_last   = is_wr_q || (tx_cnt_q == 2'd3);

    // Transmit strobe is decided in the same cycle as tx_busy so a busy UART
    // never sees a launch; it is also held off while reset is asserted.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        tx_wr_d   = 1'b0;
        tx_data_d = 8'h00;
        if (resetq && (state_q == S_TX)) begin
            tx_wr_d = !tx_busy && !tx_wr_q;
            if (is_wr_q) begin
                tx_data_d = ACK_BYTE;
            end else begin
                case (tx_cnt_q)
                    2'd0:    tx_data_d = rdata_q[31:24];
                    2'd1:    tx_data_d = rdata_q[23:16];
                    2'd2:    tx_data_d = rdata_q[15:8];
                    default: tx_data_d = rdata_q[7:0];
                endcase
            end
        end
    end

    // Frame parser, bus sequencer, reply sequencer and inter-byte timeout.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // sees the pre-edge values of the others.
        if (!resetq) begin
            state_q    <= S_IDLE;
            rx_rd_q    <= 1'b0;
            tx_wr_q    <= 1'b0;
            bus_req_q  <= 1'b0;
            io_rd_q    <= 1'b0;
            io_wr_q    <= 1'b0;
            mem_addr_q <= '0;
            dout_q     <= '0;
            is_wr_q    <= 1'b0;
            addr_sh_q  <= '0;
            data_sh_q  <= '0;
            data_cnt_q <= '0;
            rdata_q    <= '0;
            tx_cnt_q   <= '0;
            tmo_q      <= '0;
        end else begin
            rx_rd_q <= take_byte;
            tx_wr_q <= tx_wr_d;
            io_rd_q <= 1'b0;
            io_wr_q <= 1'b0;

            if (take_byte || !in_frame) begin
                tmo_q <= '0;
            end else if (!tmo_hit) begin
                tmo_q <= tmo_q + TW'(1);
            end

            case (state_q)
                S_IDLE: begin
                    // Non-command bytes are consumed and silently dropped.
                    if (take_byte && ((rx_data == CMD_READ) || (rx_data == CMD_WRITE))) begin
                        is_wr_q <= (rx_data == CMD_WRITE);
                        state_q <= S_CMD;
                    end
                end
                S_CMD: begin
                    if (take_byte) begin
                        addr_sh_q <= {addr_sh_q[7:0], rx_data};
                        state_q   <= S_ADDR;
                    end else if (tmo_hit) begin
                        state_q <= S_IDLE;
                    end
                end
                S_ADDR: begin
                    if (take_byte) begin
                        addr_sh_q <= {addr_sh_q[7:0], rx_data};
                        if (is_wr_q) begin
                            data_cnt_q <= 2'd0;
                            state_q    <= S_DATA;
                        end else begin
                            mem_addr_q <= {addr_sh_q[7:0], rx_data};
                            bus_req_q  <= 1'b1;
                            state_q    <= S_REQ;
                        end
                    end else if (tmo_hit) begin
                        state_q <= S_IDLE;
                    end
                end
                S_DATA: begin
                    if (take_byte) begin
                        data_sh_q  <= {data_sh_q[23:0], rx_data};
                        data_cnt_q <= data_cnt_q + 2'd1;
                        if (data_cnt_q == 2'd3) begin
                            mem_addr_q <= addr_sh_q;
                            dout_q     <= {data_sh_q[23:0], rx_data};
                            bus_req_q  <= 1'b1;
                            state_q    <= S_REQ;
                        end
                    end else if (tmo_hit) begin
                        state_q <= S_IDLE;
                    end
                end
                S_REQ: begin
                    if (bus_gnt) begin
                        if (is_wr_q) begin
                            io_wr_q <= 1'b1;
                            state_q <= S_WR;
                        end else begin
                            io_rd_q <= 1'b1;
                            state_q <= S_RD0;
                        end
                    end
                end
                S_RD0: begin
                    state_q <= S_RD1;
                end
                S_RD1: begin
                    // The responder registers read data one cycle after the strobe.
                    rdata_q   <= io_din;
                    bus_req_q <= 1'b0;
                    tx_cnt_q  <= 2'd0;
                    state_q   <= S_TX;
                end
                S_WR: begin
                    bus_req_q <= 1'b0;
                    tx_cnt_q  <= 2'd0;
                    state_q   <= S_TX;
                end
                S_TX: begin
                    if (tx_wr_d) begin
                        tx_cnt_q <= tx_cnt_q + 2'd1;
                        if (tx_last) begin
                            state_q <= S_IDLE;
                        end
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign rx_rd    = rx_rd_q;
    assign tx_wr    = tx_wr_d;
    assign tx_data  = tx_data_d;
    assign bus_req  = bus_req_q;
    assign io_rd    = io_rd_q;
    assign io_wr    = io_wr_q;
    assign mem_addr = mem_addr_q;
    assign dout     = dout_q;

endmodule

// File: tb/tb_io_bridge_master.sv
// tb_io_bridge_master: scoreboard bench for the UART-to-IO-bus debug bridge.
// Stimulus tasks push frame bytes into a UART receive model and push the
// expected bus cycles and reply bytes into queues; a negedge monitor pops
// and compares whenever the bridge strobes the bus or the transmitter.
module tb_io_bridge_master;

    localparam int unsigned TMO = 100;

    logic        clk = 1'b0;
    logic        resetq = 1'b0;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_rd;
    logic        tx_busy = 1'b0;
    logic        tx_wr;
    logic [7:0]  tx_data;
    logic        bus_req;
    logic        bus_gnt = 1'b0;
    logic        io_rd;
    logic        io_wr;
    logic [15:0] mem_addr;
    logic [31:0] dout;
    logic [31:0] io_din = 32'h0;

    io_bridge_master #(.TIMEOUT(TMO)) dut (
        .clk      (clk),
        .resetq   (resetq),
        .rx_valid (rx_valid),
        .rx_data  (rx_data),
        .rx_rd    (rx_rd),
        .tx_busy  (tx_busy),
        .tx_wr    (tx_wr),
        .tx_data  (tx_data),
        .bus_req  (bus_req),
        .bus_gnt  (bus_gnt),
        .io_rd    (io_rd),
        .io_wr    (io_wr),
        .mem_addr (mem_addr),
        .dout     (dout),
        .io_din   (io_din)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        wr;
        logic [15:0] addr;
        logic [31:0] data;
    } bus_t;

    bus_t        exp_bus[$];
    logic [7:0]  exp_tx[$];
    logic [7:0]  rx_q[$];
    logic [31:0] ref_mem  [logic [15:0]];
    logic [31:0] resp_mem [logic [15:0]];

    int n_checks = 0;
    int n_err    = 0;

    // Environment knobs and edge-sampled copies of DUT outputs.
    bit gnt_tie = 1'b0, gnt_deny = 1'b0, tx_force = 1'b0, rx_gap_en = 1'b0;
    int gnt_delay = 0, gnt_wait = 0, busy_cnt = 0;
    bit rd_seen = 1'b0, req_seen = 1'b0, txw_seen = 1'b0, iord_seen = 1'b0;
    logic [15:0] addr_seen = 16'h0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Default contents of the IO space (unwritten locations).
    function automatic logic [31:0] def_word(input logic [15:0] a);
        return {~a, a};
    endfunction

    function automatic logic [31:0] ref_rd(input logic [15:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : def_word(a);
    endfunction

    task automatic write_frame(input logic [15:0] a, input logic [31:0] d);
        bus_t e;
        rx_q.push_back(8'h57);
        rx_q.push_back(a[15:8]);
        rx_q.push_back(a[7:0]);
        rx_q.push_back(d[31:24]);
        rx_q.push_back(d[23:16]);
        rx_q.push_back(d[15:8]);
        rx_q.push_back(d[7:0]);
        e.wr = 1'b1; e.addr = a; e.data = d;
        exp_bus.push_back(e);
        exp_tx.push_back(8'h2B);
        ref_mem[a] = d;
    endtask

    task automatic read_frame(input logic [15:0] a);
        bus_t e;
        logic [31:0] d;
        d = ref_rd(a);
        rx_q.push_back(8'h52);
        rx_q.push_back(a[15:8]);
        rx_q.push_back(a[7:0]);
        e.wr = 1'b0; e.addr = a; e.data = 32'h0;
        exp_bus.push_back(e);
        exp_tx.push_back(d[31:24]);
        exp_tx.push_back(d[23:16]);
        exp_tx.push_back(d[15:8]);
        exp_tx.push_back(d[7:0]);
    endtask

    task automatic wait_done(input string name, input int budget);
        int n;
        n = 0;
        while ((rx_q.size() != 0 || exp_bus.size() != 0 || exp_tx.size() != 0 || bus_req)
               && n < budget) begin
            @(negedge clk);
            n++;
        end
        check({name, "_complete"}, 32'(n < budget), 32'd1);
        repeat (4) @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_strobes"}, 32'({rx_rd, tx_wr, bus_req, io_rd, io_wr}), 32'd0);
        check({tag, "_tx_data"}, 32'(tx_data), 32'd0);
        check({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
        check({tag, "_dout"}, dout, 32'd0);
    endtask

    // UART receive model: holds a byte until consumed, with optional arrival gaps.
    always @(posedge clk) begin
        #1;
        if (rd_seen && rx_q.size() > 0) void'(rx_q.pop_front());
        if (rx_q.size() == 0) rx_valid = 1'b0;
        else if (!rx_valid || rd_seen) rx_valid = !(rx_gap_en && $urandom_range(0, 3) == 0);
        rx_data = (rx_q.size() > 0) ? rx_q[0] : 8'h00;
    end

    // UART transmit model: busy for a few cycles after each launch.
    always @(posedge clk) begin
        #1;
        if (txw_seen) busy_cnt = $urandom_range(1, 4);
        else if (busy_cnt > 0) busy_cnt--;
        tx_busy = tx_force || (busy_cnt > 0);
    end

    // Bus arbiter model: grant after a programmable delay, held while requested.
    always @(posedge clk) begin
        #1;
        if (gnt_tie) begin
            bus_gnt = 1'b1;
        end else if (!req_seen) begin
            bus_gnt = 1'b0;
            gnt_wait = 0;
        end else if (gnt_deny || gnt_wait < gnt_delay) begin
            bus_gnt = 1'b0;
            gnt_wait++;
        end else begin
            bus_gnt = 1'b1;
        end
    end

    // IO responder: read data appears one cycle after the strobe, noise otherwise.
    always @(posedge clk) begin
        #1;
        if (iord_seen) io_din = resp_mem.exists(addr_seen) ? resp_mem[addr_seen] : def_word(addr_seen);
        else io_din = $urandom;
    end

    // Monitor: compares every bus strobe and every transmitted byte against the scoreboard.
    int cyc = 0;
    int strobe_cyc = -10;
    int rd_cyc = -10;
    bit strobe_was_rd = 1'b0;
    bit gnt_prev = 1'b0, strobe_prev = 1'b0, tx_prev = 1'b0, rx_prev = 1'b0;
    bus_t mon_e;
    logic [7:0] mon_b;

    always @(negedge clk) begin
        cyc++;
        if (resetq) begin
            if (io_rd || io_wr) begin
                check("strobe_exclusive", 32'(io_rd && io_wr), 32'd0);
                check("strobe_with_grant", 32'({bus_gnt, bus_req, gnt_prev}), 32'h7);
                check("strobe_single_cycle", 32'(strobe_prev), 32'd0);
                if (exp_bus.size() == 0) begin
                    check("bus_unexpected_cycle", 32'(exp_bus.size()), 32'd1);
                end else begin
                    mon_e = exp_bus.pop_front();
                    check("bus_kind_is_write", 32'(io_wr), 32'(mon_e.wr));
                    check("bus_addr", 32'(mem_addr), 32'(mon_e.addr));
                    if (mon_e.wr) check("bus_wdata", dout, mon_e.data);
                end
                if (io_wr) resp_mem[mem_addr] = dout;
                if (io_rd) rd_cyc = cyc;
                strobe_cyc = cyc;
                strobe_was_rd = io_rd;
            end
            if (cyc == strobe_cyc + 1) check("bus_req_after_strobe", 32'(bus_req), 32'(strobe_was_rd));
            if (strobe_was_rd && cyc == strobe_cyc + 2) check("bus_req_drop_after_rd1", 32'(bus_req), 32'd0);

            if (tx_wr) begin
                check("tx_wr_while_busy", 32'(tx_busy), 32'd0);
                check("tx_wr_back_to_back", 32'(tx_prev), 32'd0);
                check("tx_after_read_latency", 32'(cyc >= rd_cyc + 2), 32'd1);
                if (exp_tx.size() == 0) begin
                    check("tx_unexpected_byte", 32'(exp_tx.size()), 32'd1);
                end else begin
                    mon_b = exp_tx.pop_front();
                    check("tx_byte", 32'(tx_data), 32'(mon_b));
                end
            end

            if (rx_rd) begin
                check("rx_rd_with_valid", 32'(rx_valid), 32'd1);
                check("rx_rd_back_to_back", 32'(rx_prev), 32'd0);
            end
        end
        gnt_prev    = bus_gnt;
        strobe_prev = io_rd || io_wr;
        tx_prev     = tx_wr;
        rx_prev     = rx_rd;
        rd_seen     = rx_rd;
        req_seen    = bus_req;
        txw_seen    = tx_wr;
        iord_seen   = io_rd;
        addr_seen   = mem_addr;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: time limit reached with %0d errors", n_err);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int bad;
        logic [7:0] g;
        logic [15:0] a;
        logic [15:0] pool [4];

        ref_mem[16'h1008]  = 32'h000E1000;
        resp_mem[16'h1008] = 32'h000E1000;
        pool[0] = 16'h0404; pool[1] = 16'h1008; pool[2] = 16'h00F0; pool[3] = 16'hFFFF;

        // Reset state.
        resetq = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk); #1 resetq = 1'b1;

        // Write with grant tied high.
        gnt_tie = 1'b1;
        write_frame(16'h0404, 32'h000000A5);
        wait_done("write_0404", 500);
        gnt_tie = 1'b0;

        // Read with a responder returning 0x000E1000 for 0x1008.
        read_frame(16'h1008);
        wait_done("read_1008", 500);

        // Read with grant withheld for 50 cycles.
        gnt_deny = 1'b1;
        read_frame(16'h0404);
        n = 0;
        while (!bus_req && n < 200) begin @(negedge clk); n++; end
        check("held_grant_req_seen", 32'(bus_req), 32'd1);
        bad = 0;
        repeat (50) begin
            @(negedge clk);
            if (!bus_req || io_rd) bad++;
        end
        check("held_grant_req_without_rd", 32'(bad), 32'd0);
        gnt_deny = 1'b0;
        wait_done("held_grant_read", 500);

        // Partial write frame abandoned by the timeout, then a clean read.
        rx_q.push_back(8'h57);
        rx_q.push_back(8'h00);
        n = 0;
        while (rx_q.size() != 0 && n < 100) begin @(negedge clk); n++; end
        repeat (150) @(negedge clk);
        read_frame(16'h0400);
        wait_done("timeout_then_read", 500);

        // Garbage bytes are eaten silently before a read.
        rx_q.push_back(8'h00);
        rx_q.push_back(8'hFF);
        rx_q.push_back(8'h41);
        read_frame(16'h0005);
        wait_done("garbage_then_read", 500);

        // Transmitter busy for 200 cycles during a read reply.
        tx_force = 1'b1;
        read_frame(16'h1008);
        n = 0;
        while (exp_bus.size() != 0 && n < 500) begin @(negedge clk); n++; end
        check("busy_tx_bus_cycle_done", 32'(exp_bus.size()), 32'd0);
        bad = 0;
        repeat (200) begin
            @(negedge clk);
            if (tx_wr) bad++;
        end
        check("busy_tx_no_launch", 32'(bad), 32'd0);
        check("busy_tx_bytes_pending", 32'(exp_tx.size()), 32'd4);
        tx_force = 1'b0;
        wait_done("busy_tx_read", 500);

        // Reset in the middle of a read reply.
        read_frame(16'h0404);
        n = 0;
        while (exp_tx.size() > 3 && n < 500) begin @(negedge clk); n++; end
        check("midreply_first_byte_sent", 32'(exp_tx.size()), 32'd3);
        @(posedge clk); #1 resetq = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_reset_outputs("midreply_reset");
        exp_tx.delete();
        @(posedge clk); #1 resetq = 1'b1;
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (tx_wr || bus_req || io_rd || io_wr || rx_rd) bad++;
        end
        check("midreply_quiet_after_reset", 32'(bad), 32'd0);

        // Randomized frames with random grant delay, rx gaps and tx busy lengths.
        rx_gap_en = 1'b1;
        for (int i = 0; i < 40; i++) begin
            gnt_tie   = ($urandom_range(0, 4) == 0);
            gnt_delay = $urandom_range(0, 6);
            if ($urandom_range(0, 3) == 0) begin
                g = 8'($urandom_range(0, 255));
                if (g == 8'h52 || g == 8'h57) g = 8'h00;
                rx_q.push_back(g);
            end
            a = ($urandom_range(0, 1) == 1) ? pool[$urandom_range(0, 3)] : 16'($urandom);
            if ($urandom_range(0, 1) == 1) write_frame(a, $urandom);
            else read_frame(a);
            wait_done("random_frame", 2000);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/io_bridge_master.md
# io_bridge_master

Serial debug bridge: a second initiator on the J1 memory-mapped IO bus, letting a host peek and poke IO registers over a UART byte stream without CPU involvement. It parses read and write command frames from the UART receive side and runs single IO bus cycles with the same timing the J1 uses. It returns read data or an acknowledge byte on the UART transmit side. It sits beside the J1; the top level muxes the IO bus between the two using `bus_req`/`bus_gnt`.

## Interface

- `TIMEOUT`, default 2500000: inter-byte timeout in clock cycles (100 ms at 25 MHz); a partial frame is abandoned after this many idle cycles.
- `clk` input 1: system clock.
- `resetq` input 1: reset, synchronous, active-low.
- `rx_valid` input 1: UART receive byte available; stays high until consumed.
- `rx_data` input 8: UART receive byte.
- `rx_rd` output 1: one-cycle pulse consuming the current receive byte.
- `tx_busy` input 1: UART transmitter busy.
- `tx_wr` output 1: one-cycle pulse launching `tx_data`.
- `tx_data` output 8: byte to transmit; valid whenever `tx_wr` is high.
- `bus_req` output 1: bridge requests the IO bus.
- `bus_gnt` input 1: top level has handed the IO bus to the bridge.
- `io_rd` output 1: IO read strobe.
- `io_wr` output 1: IO write strobe.
- `mem_addr` output 16: IO address.
- `dout` output 32: IO write data.
- `io_din` input 32: IO read data, registered by the responder one cycle after the address.

## Operation

Frames are big-endian.
- Write frame: 0x57 ('W'), addr[15:8], addr[7:0], d[31:24], d[23:16], d[15:8], d[7:0]. The bridge runs one write cycle, then transmits 0x2B ('+').
- Read frame: 0x52 ('R'), addr[15:8], addr[7:0]. The bridge runs one read cycle, then transmits 4 bytes, MSB first.
- Any other byte in IDLE is consumed and discarded with no reply.

States and transitions:
- IDLE → CMD on a 'R' or 'W' byte.
- CMD/ADDR collect 2 address bytes; for 'W', DATA collects 4 bytes.
- Then REQ: `bus_req`=1, wait for `bus_gnt`.
- Read path: RD0 → RD1.
- Write path: WR.
- Then TX → IDLE.

Byte intake:
- `rx_rd` pulses in the cycle a byte is accepted.
- The bridge does not sample `rx_valid` in the cycle after an `rx_rd` pulse.
- The received byte shifts into a 16-bit address register or 32-bit data register.

Bus cycles (only while `bus_gnt`=1):
- RD0: `io_rd`=1 for exactly one cycle; `mem_addr` is driven.
- RD1: `mem_addr` is held and `io_din` is captured into the read register at the end of this cycle.
- WR: `io_wr`=1 for exactly one cycle, with `mem_addr` and `dout` valid in that cycle.
- `bus_req` drops the cycle after RD1 or WR.
- If `bus_gnt` falls during REQ, the bridge keeps waiting. `bus_gnt` is only sampled in REQ; the top guarantees grant is held until `bus_req` falls.

Transmit:
- `tx_wr` is asserted only when `tx_busy`=0 and `tx_wr` was 0 in the previous cycle.
- `tx_data` is loaded from the read register MSB first, or is 0x2B for a write.

Timeout:
- A counter resets on every accepted byte.
- In CMD/ADDR/DATA, if it reaches `TIMEOUT` the partial frame is dropped and the state returns to IDLE with no reply and no bus cycle.
- The timeout is inactive in IDLE, REQ and TX.

Other rules:
- Bytes arriving during REQ/RD/WR/TX stay in the UART; they are not consumed until IDLE.
- `mem_addr`/`dout` are registers that change only when a new frame loads them.

## Timing

- Reset (`resetq`=0 at a clock edge): all outputs are 0 — `rx_rd`, `tx_wr`, `tx_data`, `bus_req`, `io_rd`, `io_wr`, `mem_addr`, `dout` — and the state is IDLE.
- Reset mid-frame or mid-TX aborts with no further strobes.
- `rx_valid` high in IDLE: `rx_rd` pulses on the next cycle.
- Byte acceptance throughput: at most 1 byte per 2 cycles.
- Last frame byte accepted to `bus_req`=1: 1 cycle.
- `bus_gnt` high to `io_rd`/`io_wr` high: 1 cycle.
- Read: `io_rd` in cycle N, `io_din` captured at end of cycle N+1, first `tx_wr` no earlier than N+2.
- `io_rd` and `io_wr` are never high simultaneously, and never high without `bus_gnt`.

## Test plan

- 'W',0x04,0x04,0x00,0x00,0x00,0xA5 with `bus_gnt` tied 1 → single `io_wr` cycle with `mem_addr`=0x0404 and `dout`=0x000000A5, then one `tx_wr` with 0x2B.
- 'R',0x10,0x08; responder model returns 0x000E1000 for 0x1008 one cycle late → `io_rd` one cycle, tx bytes 0x00,0x0E,0x10,0x00 in order.
- Read with `bus_gnt` held 0 for 50 cycles → `bus_req`=1 throughout, no `io_rd` until grant, then normal completion.
- `TIMEOUT`=100: 'W',0x00 then silence for 150 cycles, then 'R',0x04,0x00 → no `io_wr`; the read completes correctly at 0x0400.
- Garbage bytes 0x00,0xFF,0x41 followed by 'R',0x00,0x05 → garbage consumed silently; exactly 4 reply bytes.
- `tx_busy` held high for 200 cycles during a read reply → `tx_wr` stays low; all 4 bytes are sent afterwards; `resetq` low mid-reply → outputs 0 and IDLE on the next edge.
